// File: rtl/cpu0_mem_ctrl.sv
// cpu0_mem_ctrl: cpu0 bus to word-wide single-port SRAM bridge (big-endian, any-alignment
// byte/16/24/32-bit accesses, read-modify-write for sub-word writes, split on word crossing).
// Ports:
//   i_clock, i_reset          clock, asynchronous active-high reset
//   i_en, i_rw, i_size        request strobe (rising edge), 1=read/0=write, length-1 in bytes
//   i_addr, i_wdata           byte address, write data (low N bytes used)
//   o_rdata                   read data, right-aligned and zero-extended, held until next read
//   o_ready, o_err, o_busy    completion pulse, out-of-range flag (with ready), not-idle
//   o_sram_*, i_sram_rdata    SRAM strobe/write/word address/write word, read word (1-cycle latency)
module cpu0_mem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_en,
    input  logic          i_rw,
    input  logic [1:0]    i_size,
    input  logic [31:0]   i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata,
    output logic          o_ready,
    output logic          o_err,
    output logic          o_busy,
    output logic          o_sram_en,
    output logic          o_sram_we,
    output logic [AW-1:0] o_sram_addr,
    output logic [31:0]   o_sram_wdata,
    input  logic [31:0]   i_sram_rdata
);
    typedef enum logic [2:0] {IDLE, RD0, RW0, RD1, RW1, WR0, WR1, DONE} state_t;
    state_t        r_state, w_next;
    logic          r_en_q, r_rw, r_cross, r_err;
    logic [1:0]    r_size;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata, r_rdata, w_rd;
    logic [63:0]   r_buf, w_buf, w_mask, w_data, w_mrg;
    logic [AW-1:0] w_w0, w_w1;
    logic [4:0]    w_lsh, w_nsh;
    logic [5:0]    w_rsh;
    logic          w_accept, w_oor, w_cross, w_full;

    assign w_accept = (r_state == IDLE) && i_en && !r_en_q;
    // full 33-bit sum so addresses near 2^32 cannot wrap back into range
    assign w_oor    = ({1'b0, i_addr} + 33'(i_size)) >= 33'(4 * DEPTH_WORDS);
    assign w_cross  = (3'(i_addr[1:0]) + 3'(i_size)) > 3'd3;
    assign w_full   = (i_size == 2'd3) && (i_addr[1:0] == 2'd0);

    assign w_w0  = r_addr[AW+1:2];
    assign w_w1  = w_w0 + AW'(1);
    assign w_lsh = {r_addr[1:0], 3'b000};
    assign w_nsh = {2'd3 - r_size, 3'b000};
    assign w_rsh = {3'd7 - 3'(r_addr[1:0]) - 3'(r_size), 3'b000};

    // buffer view including the SRAM word arriving this cycle, so data is usable on the capture edge
    assign w_buf  = {r_state == RW0 ? i_sram_rdata : r_buf[63:32],
                     r_state == RW1 ? i_sram_rdata : r_buf[31:0]};
    assign w_rd   = 32'(w_buf >> w_rsh) & (32'hFFFF_FFFF >> w_nsh);
    assign w_mask = {32'hFFFF_FFFF << w_nsh, 32'h0} >> w_lsh;
    assign w_data = {r_wdata << w_nsh, 32'h0} >> w_lsh;
    assign w_mrg  = (w_buf & ~w_mask) | w_data;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !w_accept ? IDLE : w_oor ? DONE : (!i_rw && w_full) ? WR0 : RD0;
            RD0:     w_next = RW0;
            RW0:     w_next = r_cross ? RD1 : r_rw ? DONE : WR0;
            RD1:     w_next = RW1;
            RW1:     w_next = r_rw ? DONE : WR0;
            WR0:     w_next = r_cross ? WR1 : DONE;
            WR1:     w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_en_q  <= 1'b0;
            r_rw    <= 1'b0;
            r_cross <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_next;
            r_en_q  <= i_en;
            if (w_accept) begin
                r_rw    <= i_rw;
                r_size  <= i_size;
                r_addr  <= i_addr[AW+1:0];
                r_wdata <= i_wdata;
                r_cross <= w_cross;
                r_err   <= w_oor;
            end
            if (r_state == RW0 || r_state == RW1)
                r_buf <= w_buf;
            if (w_next == DONE && r_state == IDLE && i_rw)
                r_rdata <= '0;
            if (w_next == DONE && (r_state == RW0 || r_state == RW1))
                r_rdata <= w_rd;
        end
    end

    assign o_rdata      = r_rdata;
    assign o_ready      = r_state == DONE;
    assign o_err        = o_ready && r_err;
    assign o_busy       = r_state != IDLE;
    assign o_sram_en    = r_state == RD0 || r_state == RD1 || r_state == WR0 || r_state == WR1;
    assign o_sram_we    = r_state == WR0 || r_state == WR1;
    assign o_sram_addr  = (r_state == RD1 || r_state == WR1) ? w_w1 :
                          (r_state == RD0 || r_state == WR0) ? w_w0 : '0;
    assign o_sram_wdata = r_state == WR0 ? w_mrg[63:32] : r_state == WR1 ? w_mrg[31:0] : '0;
endmodule

// File: tb/tb_cpu0_mem_ctrl.sv
// tb_cpu0_mem_ctrl: bench for cpu0_mem_ctrl with a byte-array reference model and SRAM model.
module tb_cpu0_mem_ctrl;
    localparam int DW = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst, en, rw, sen, swe, ready, err, busy, ld;
    logic [1:0]    size;
    logic [31:0]   addr, wdata, rdata, swd, srd;
    logic [AW-1:0] saddr;
    logic [31:0]   mem [DW];
    logic [31:0]   img [DW];
    logic [7:0]    mb [DW*4];
    logic [31:0]   hold_rd;
    int            tests, fails;
    string         cur;

    always #5 clk = ~clk;

    cpu0_mem_ctrl #(.DEPTH_WORDS(DW), .AW(AW)) dut (
        .i_clock(clk), .i_reset(rst), .i_en(en), .i_rw(rw), .i_size(size),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_ready(ready),
        .o_err(err), .o_busy(busy), .o_sram_en(sen), .o_sram_we(swe),
        .o_sram_addr(saddr), .o_sram_wdata(swd), .i_sram_rdata(srd)
    );

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < DW; i++) mem[i] <= img[i];
        end else if (sen) begin
            if (swe) mem[saddr] <= swd;
            else srd <= mem[saddr];
        end
    end

    typedef struct {
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          k;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s/%s: got %h, expected %h", cur, nm, act, exp_v);
        end
    endtask

    function automatic logic [31:0] word_of(int w);
        return {mb[4*w], mb[4*w+1], mb[4*w+2], mb[4*w+3]};
    endfunction

    task automatic load_img();
        for (int w = 0; w < DW; w++) img[w] = word_of(w);
        @(negedge clk); ld = 1'b1;
        @(negedge clk); ld = 1'b0;
    endtask

    task automatic check_mem(input string nm);
        int bad = 0;
        for (int w = 0; w < DW; w++) if (mem[w] !== word_of(w)) bad++;
        check(nm, bad, 0);
    endtask

    // Reference: byte-addressed memory, big-endian packing, latency/pulse counts from the access kind.
    task automatic model(input logic r_w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] r, output logic e, output int k, output int ne, output int nw);
        int     n   = int'(sz) + 1;
        int     off = int'(a[1:0]);
        longint lst = longint'(a) + longint'(n) - 1;
        bit     crs = (off + n) > 4;
        bit     ful = (n == 4) && (off == 0);
        logic [31:0] v = '0;
        e = 1'b0; nw = 0;
        if (lst >= longint'(DW * 4)) begin
            e = 1'b1; k = 1; ne = 0;
            if (r_w) hold_rd = '0;
        end else if (r_w) begin
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(mb[int'(a) + i]);
            hold_rd = v;
            k  = crs ? 5 : 3;
            ne = crs ? 2 : 1;
        end else begin
            for (int i = 0; i < n; i++) mb[int'(a) + i] = wd[8*(n-1-i) +: 8];
            k  = ful ? 2 : crs ? 7 : 4;
            ne = ful ? 1 : crs ? 4 : 2;
            nw = crs ? 2 : 1;
        end
        r = hold_rd;
    endtask

    task automatic access(input logic r_w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] r, output logic e, output int k, output int ne, output int nw,
                          output logic [AW-1:0] af, output logic [AW-1:0] al);
        bit done = 1'b0;
        @(negedge clk);
        check("idle_before", {30'b0, busy, ready}, 32'h0);
        en = 1'b1; rw = r_w; size = sz; addr = a; wdata = wd;
        k = 0; ne = 0; nw = 0; r = 'x; e = 1'bx; af = '0; al = '0;
        while (!done && k < 12) begin
            @(negedge clk);
            k++;
            if (k == 1) en = 1'b0;
            if (sen) begin
                if (ne == 0) af = saddr;
                al = saddr;
                ne++;
                if (swe) nw++;
            end
            if (ready) begin
                done = 1'b1; r = rdata; e = err;
            end
        end
        check("ready_seen", 32'(done), 32'h1);
    endtask

    task automatic run(input logic r_w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       input bit tbl, input logic [31:0] tr, input logic te, input int tk);
        logic [31:0]   mr, gr;
        logic          me, ge;
        int            mk, mne, mnw, gk, gne, gnw;
        logic [AW-1:0] af, al;
        bit            crs = (int'(a[1:0]) + int'(sz) + 1) > 4;
        model(r_w, sz, a, wd, mr, me, mk, mne, mnw);
        access(r_w, sz, a, wd, gr, ge, gk, gne, gnw, af, al);
        check("rdata", gr, tbl ? tr : mr);
        check("err", 32'(ge), 32'(tbl ? te : me));
        check("latency", gk, tbl ? tk : mk);
        check("en_pulses", gne, mne);
        check("we_pulses", gnw, mnw);
        if (gne > 0) begin
            check("addr_first", 32'(af), 32'(a[9:2]));
            check("addr_last", 32'(al), 32'(crs ? 8'(a[9:2] + 8'd1) : a[9:2]));
        end
    endtask

    vec_t tbl [14];

    initial begin
        tests = 0; fails = 0; hold_rd = '0; cur = "reset";
        rst = 1'b1; en = 1'b0; rw = 1'b0; size = '0; addr = '0; wdata = '0; ld = 1'b0;
        #12;
        check("rdata", rdata, 32'h0);
        check("ctl", {27'b0, ready, err, busy, sen, swe}, 32'h0);
        check("sram_addr", 32'(saddr), 32'h0);
        check("sram_wdata", swd, 32'h0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < DW*4; i++) mb[i] = 8'h00;
        for (int i = 0; i < 8; i++) mb[i] = 8'(8'h11 * (i + 1));
        load_img();

        tbl[0]  = '{1'b1, 2'd3, 32'd0,         32'h0,        32'h11223344, 1'b0, 3};
        tbl[1]  = '{1'b1, 2'd1, 32'd3,         32'h0,        32'h00004455, 1'b0, 5};
        tbl[2]  = '{1'b0, 2'd0, 32'd5,         32'h000000AB, 32'h00004455, 1'b0, 4};
        tbl[3]  = '{1'b0, 2'd3, 32'd2,         32'hDEADBEEF, 32'h00004455, 1'b0, 7};
        tbl[4]  = '{1'b1, 2'd3, 32'd1022,      32'h0,        32'h00000000, 1'b1, 1};
        tbl[5]  = '{1'b1, 2'd3, 32'd3,         32'h0,        32'hADBEEF77, 1'b0, 5};
        tbl[6]  = '{1'b0, 2'd2, 32'd1021,      32'hFF123456, 32'hADBEEF77, 1'b0, 4};
        tbl[7]  = '{1'b1, 2'd1, 32'd1023,      32'h0,        32'h00000000, 1'b1, 1};
        tbl[8]  = '{1'b1, 2'd2, 32'd1021,      32'h0,        32'h00123456, 1'b0, 3};
        tbl[9]  = '{1'b0, 2'd3, 32'd0,         32'hCAFEF00D, 32'h00123456, 1'b0, 2};
        tbl[10] = '{1'b1, 2'd0, 32'd2,         32'h0,        32'h000000F0, 1'b0, 3};
        tbl[11] = '{1'b1, 2'd3, 32'hFFFFFFFE,  32'h0,        32'h00000000, 1'b1, 1};
        tbl[12] = '{1'b1, 2'd3, 32'd1020,      32'h0,        32'h00123456, 1'b0, 3};
        tbl[13] = '{1'b0, 2'd1, 32'd1023,      32'h00009999, 32'h00123456, 1'b1, 1};
        for (int i = 0; i < 14; i++) begin
            cur = $sformatf("vec%0d", i);
            run(tbl[i].rw, tbl[i].size, tbl[i].addr, tbl[i].wdata, 1'b1, tbl[i].rdata, tbl[i].err, tbl[i].k);
            if (i == 2) check("w0_kept", mem[0], 32'h11223344);
            if (i == 2) check("w1_byte", mem[1], 32'h55AB7788);
            if (i == 3) check("w0_split", mem[0], 32'h1122DEAD);
            if (i == 3) check("w1_split", mem[1], 32'hBEEF7788);
        end
        cur = "table";
        check_mem("mem_image");

        begin
            logic [31:0] mr;
            logic        me;
            int          mk, mne, mnw, k, busy_seen;
            bit          done;
            cur = "drop";
            model(1'b0, 2'd3, 32'd2, 32'h5A5AA5A5, mr, me, mk, mne, mnw);
            @(negedge clk);
            en = 1'b1; rw = 1'b0; size = 2'd3; addr = 32'd2; wdata = 32'h5A5AA5A5;
            k = 0; done = 1'b0;
            while (!done && k < 12) begin
                @(negedge clk);
                k++;
                if (k == 1) en = 1'b0;
                if (k == 2) begin
                    en = 1'b1; rw = 1'b1; size = 2'd0; addr = 32'd100;
                end
                done = ready;
            end
            check("latency", k, 7);
            busy_seen = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (busy) busy_seen++;
            end
            check("not_accepted", busy_seen, 0);
            en = 1'b0;
            check_mem("mem_image");
        end

        begin
            int pulses;
            cur = "reset_rw1";
            @(negedge clk);
            en = 1'b1; rw = 1'b0; size = 2'd3; addr = 32'd6; wdata = 32'h01020304;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                if (c == 1) en = 1'b0;
            end
            check("busy_before", 32'(busy), 32'h1);
            rst = 1'b1;
            #1;
            check("drop", {28'b0, ready, busy, sen, swe}, 32'h0);
            pulses = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (sen || swe || ready) pulses++;
            end
            check("quiet", pulses, 0);
            rst = 1'b0;
            check_mem("mem_image");
            run(1'b1, 2'd3, 32'd6, 32'h0, 1'b0, 32'h0, 1'b0, 0);
        end

        cur = "random";
        for (int i = 0; i < DW*4; i++) mb[i] = 8'($urandom);
        load_img();
        for (int i = 0; i < 300; i++) begin
            int          r = int'($urandom_range(0, 9));
            logic [31:0] a = r == 0 ? $urandom : r == 1 ? 32'(1024 - int'($urandom_range(0, 4))) :
                             32'($urandom_range(0, 1023));
            run(1'($urandom), 2'($urandom), a, $urandom, 1'b0, 32'h0, 1'b0, 0);
        end
        check_mem("mem_image");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
